serial_frame_ctrl: RTL and testbench
====================================

// Module: serial_frame_ctrl
// PURPOSE
//  Sequencer for the serial message receiver. Decodes frames on serIn: start bit, 2-bit port id,
//  8-bit length (collected by the external nt_counter), then `nt` payload bits.
//  Drives nt_counter's enable, latches the length, and forwards payload bits to one of NPORTS outputs.
//  Pulses `done` at the end of each frame.
// PARAMETERS
//  NPORTS  4  number of output ports; port id width PORT_W = $clog2(NPORTS) = 2
//  LEN_W   8  payload length width; must match nt_counter's nt width
//  CNT_W   8  per-port frame counter width (MSG_COUNT_EN only)
// PORTS
//  clk          in   1             rising-edge clock
//  rst          in   1             asynchronous, active-high reset
//  serIn        in   1             serial line; idles high
//  nt_valid     in   1             from nt_counter serOutValid: length word complete
//  nt           in   LEN_W         from nt_counter: payload length
//  nt_en        out  1             enable to nt_counter; high only in LEN state
//  port_sel     out  PORT_W        latched port id of the current frame
//  data_out     out  1             registered payload bit
//  data_valid   out  NPORTS        one-hot: data_out is valid for port i
//  busy         out  1             high in any state other than IDLE
//  done         out  1             one-cycle end-of-frame pulse
//  msg_cnt      out  NPORTS*CNT_W  per-port completed-frame counts; present only with MSG_COUNT_EN
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; port_sel=0; data_out=0; data_valid=0; nt_en=0; busy=0;
//   done=0; remaining=0; msg_cnt=0. All outputs clear immediately, without waiting for a clock edge.
//  FSM: IDLE -> PORT -> LEN -> DATA -> DONE -> IDLE.
//  IDLE: serIn==0 sampled at a clk edge is the start bit -> PORT. serIn==1 -> stay in IDLE.
//  PORT: exactly PORT_W cycles; shift serIn into port_sel, MSB first; then -> LEN.
//  LEN: nt_en=1 (registered, asserted on the first LEN cycle). Wait for nt_valid.
//   On a cycle with nt_valid=1: remaining<=nt; nt_en drops next cycle.
//   If nt==0 -> DONE (no payload); otherwise -> DATA.
//  DATA: each cycle, data_out<=serIn and data_valid<=(1<<port_sel); remaining<=remaining-1.
//   Leave for DONE on the cycle where remaining==1.
//   data_out/data_valid lag serIn by 1 cycle; data_valid is high for exactly nt cycles.
//  DONE: done=1 for exactly one cycle; data_valid=0; -> IDLE.
//   serIn is ignored in DONE; a start bit is recognised only in IDLE.
//  remaining never wraps: it is loaded only in LEN and decremented only while nonzero.
//  busy=1 from the first PORT cycle through DONE inclusive.
//  nt_valid arriving outside LEN is ignored.
// CONFIGURATION
//  MSG_COUNT_EN defined: msg_cnt port exists. msg_cnt[port_sel*CNT_W +: CNT_W] increments in DONE.
//   Frames with nt==0 are counted. Counters wrap modulo 2^CNT_W.
//  MSG_COUNT_EN undefined: no msg_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//  Package ser_ctrl_pkg: state encoding (IDLE, PORT, LEN, DATA, DONE; 3-bit) and PORT_W/LEN_W constants.
//  Sub-module port_msg_stats: NPORTS x CNT_W counter bank (inc, port_sel -> msg_cnt).
//   Instantiated only under MSG_COUNT_EN.
//  nt_counter stays external; this block only drives nt_en and consumes nt/nt_valid.
// TESTING
//  1 rst=1 in mid-frame, async -> all outputs 0 before the next edge; after release, line high ->
//    busy stays 0.
//  2 start, port=2'b10, nt=8'd3, payload 1,0,1 -> data_valid=4'b0100 for 3 cycles;
//    data_out=1,0,1; done pulses on the cycle after the last valid.
//  3 port=2'b01, nt=8'd0 -> data_valid never asserts; done pulses the cycle after LEN exits.
//  4 nt=8'd255 to port 3 -> exactly 255 data_valid cycles on bit 3 only; then one done.
//  5 serIn=0 during DONE, then a proper start in IDLE -> only the second start opens a frame;
//    frames back-to-back OK.
//  6 MSG_COUNT_EN: frames to ports 1,1,3 -> cnt[1]=2, cnt[3]=1, others 0;
//    256 frames to port 0 -> cnt[0]=0 (wrap).

Source files
------------

// File: rtl/ser_ctrl_pkg.sv
// Shared constants for the serial frame sequencer: port/length widths and
// the 3-bit state encoding used by serial_frame_ctrl.
package ser_ctrl_pkg;

  localparam int NPORTS = 4;
  localparam int PORT_W = $clog2(NPORTS);
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PORT = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/port_msg_stats.sv
// Per-port completed-frame counter bank; each counter wraps modulo 2^CNT_W.
// Only built when MSG_COUNT_EN is defined.
`ifdef MSG_COUNT_EN
module port_msg_stats
  import ser_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic [PORT_W-1:0]       port_sel,
  output logic [NPORTS*CNT_W-1:0] msg_cnt
);

  logic [CNT_W-1:0] cnt_q [NPORTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (inc) begin
      cnt_q[port_sel] <= cnt_q[port_sel] + 1'b1;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_flat
    assign msg_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
`endif

// File: rtl/serial_frame_ctrl.sv
// Frame sequencer for the serial message receiver: start bit, port id, length
// (via external nt_counter), payload routing. Optional MSG_COUNT_EN adds per-port frame counts.
module serial_frame_ctrl
  import ser_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    serIn,
  input  logic                    nt_valid,
  input  logic [LEN_W-1:0]        nt,
  output logic                    nt_en,
  output logic [PORT_W-1:0]       port_sel,
  output logic                    data_out,
  output logic [NPORTS-1:0]       data_valid,
  output logic                    busy,
  output logic                    done
`ifdef MSG_COUNT_EN
  ,
  output logic [NPORTS*CNT_W-1:0] msg_cnt
`endif
);

  localparam logic [PORT_W-1:0] PORT_LAST = PORT_W[PORT_W-1:0] - 1'b1;
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [PORT_W-1:0] port_sel_q, port_sel_d;
  logic [PORT_W-1:0] bitCnt_q, bitCnt_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              nt_en_q, nt_en_d;
  logic              data_out_q, data_out_d;
  logic [NPORTS-1:0] data_valid_q, data_valid_d;
  logic              done_q, done_d;
  logic [PORT_W:0]   portShift;

  assign portShift = {port_sel_q, serIn};

  always_comb begin
    state_d      = state_q;
    port_sel_d   = port_sel_q;
    bitCnt_d     = bitCnt_q;
    remaining_d  = remaining_q;
    nt_en_d      = nt_en_q;
    data_out_d   = data_out_q;
    data_valid_d = '0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!serIn) begin
          state_d  = ST_PORT;
          bitCnt_d = '0;
        end
      end
      ST_PORT: begin
        port_sel_d = portShift[PORT_W-1:0];
        bitCnt_d   = bitCnt_q + 1'b1;
        if (bitCnt_q == PORT_LAST) begin
          state_d = ST_LEN;
          nt_en_d = 1'b1;
        end
      end
      ST_LEN: begin
        if (nt_valid) begin
          remaining_d = nt;
          nt_en_d     = 1'b0;
          state_d     = (nt == '0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        data_out_d   = serIn;
        data_valid_d = {{(NPORTS-1){1'b0}}, 1'b1} << port_sel_q;
        if (remaining_q != '0) begin
          remaining_d = remaining_q - 1'b1;
        end
        // A zero count here is unreachable; treat it like the last bit rather than wrap.
        if (remaining_q <= LEN_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      port_sel_q   <= '0;
      bitCnt_q     <= '0;
      remaining_q  <= '0;
      nt_en_q      <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_sel_q   <= port_sel_d;
      bitCnt_q     <= bitCnt_d;
      remaining_q  <= remaining_d;
      nt_en_q      <= nt_en_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
    end
  end

  assign nt_en      = nt_en_q;
  assign port_sel   = port_sel_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef MSG_COUNT_EN
  port_msg_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .inc      (state_q == ST_DONE),
    .port_sel (port_sel_q),
    .msg_cnt  (msg_cnt)
  );
`endif

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl: randomized frames, a frame-level reference
// model feeding an expectation queue, and a decoupled output monitor. Honours MSG_COUNT_EN.
module tb_serial_frame_ctrl;
  import ser_ctrl_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    serIn;
  logic                    nt_valid;
  logic [LEN_W-1:0]        nt;
  logic                    nt_en;
  logic [PORT_W-1:0]       port_sel;
  logic                    data_out;
  logic [NPORTS-1:0]       data_valid;
  logic                    busy;
  logic                    done;
`ifdef MSG_COUNT_EN
  logic [NPORTS*CNT_W-1:0] msg_cnt;
`endif

  serial_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .serIn      (serIn),
    .nt_valid   (nt_valid),
    .nt         (nt),
    .nt_en      (nt_en),
    .port_sel   (port_sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
`ifdef MSG_COUNT_EN
    ,
    .msg_cnt    (msg_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isDone;
    bit          hadPayload;
    int          port;
    logic        bitVal;
  } exp_t;

  exp_t expQ[$];
  int   testsRun  = 0;
  int   failures  = 0;
  bit   monitorOn = 1'b0;
  bit   prevValid = 1'b0;
  int   expCnt[NPORTS];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every cycle the DUT shows a payload bit or a done pulse, it must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (monitorOn && !rst && (data_valid !== '0 || done !== 1'b0)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected output", {27'd0, data_valid, done}, 32'd0);
      end else begin
        e = expQ.pop_front();
        if (e.isDone) begin
          checkOutput("done pulse", done, 1);
          checkOutput("data_valid during done", data_valid, 0);
          checkOutput("done timing vs last valid", prevValid, e.hadPayload);
        end else begin
          checkOutput("data_valid port", data_valid, 32'd1 << e.port);
          checkOutput("data_out bit", data_out, e.bitVal);
          checkOutput("done during payload", done, 0);
        end
      end
    end
    prevValid = (data_valid !== '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: idle gap, start bit, port id MSB first, nt_counter handshake, payload, DONE cycle.
  task automatic applyStimulus(input int port, input int len, input logic [255:0] bits,
                               input int gap, input logic doneLine);
    exp_t e;
    logic [PORT_W-1:0] pv;
    pv = PORT_W'(port);
    for (int i = 0; i < gap; i++) begin
      serIn    = 1'b1;
      nt_valid = ($urandom_range(0, 3) == 0);
      nt       = LEN_W'($urandom);
      tick();
      checkOutput("busy while idle", busy, 0);
    end
    for (int i = 0; i < len; i++) begin
      e = '{isDone: 1'b0, hadPayload: 1'b0, port: port, bitVal: bits[i]};
      expQ.push_back(e);
    end
    e = '{isDone: 1'b1, hadPayload: (len > 0), port: port, bitVal: 1'b0};
    expQ.push_back(e);

    serIn    = 1'b0;
    nt_valid = 1'b0;
    tick();
    checkOutput("busy after start", busy, 1);
    for (int b = PORT_W - 1; b >= 0; b--) begin
      serIn = pv[b];
      tick();
    end
    checkOutput("nt_en in length phase", nt_en, 1);
    checkOutput("port_sel latched", port_sel, pv);
    repeat ($urandom_range(0, 3)) begin
      serIn = 1'($urandom);
      tick();
    end
    nt_valid = 1'b1;
    nt       = LEN_W'(len);
    serIn    = 1'($urandom);
    tick();
    nt_valid = 1'b0;
    nt       = LEN_W'($urandom);
    checkOutput("nt_en drops after length", nt_en, 0);
    for (int i = 0; i < len; i++) begin
      serIn = bits[i];
      tick();
    end
    checkOutput("busy in done state", busy, 1);
    serIn = doneLine;
    tick();
    checkOutput("done follows frame", done, 1);
    serIn = 1'b1;
    expCnt[port] = (expCnt[port] + 1) % (1 << CNT_W);
  endtask

  task automatic randomBits(output logic [255:0] bits);
    for (int i = 0; i < 8; i++) begin
      bits[i*32 +: 32] = $urandom;
    end
  endtask

`ifdef MSG_COUNT_EN
  task automatic checkCounts(input string name);
    for (int p = 0; p < NPORTS; p++) begin
      checkOutput(name, msg_cnt[p*CNT_W +: CNT_W], expCnt[p]);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [255:0] bits;
    for (int p = 0; p < NPORTS; p++) expCnt[p] = 0;
    rst      = 1'b1;
    serIn    = 1'b1;
    nt_valid = 1'b0;
    nt       = '0;
    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset nt_en", nt_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Abort a frame mid-payload with an asynchronous reset.
    serIn = 1'b0; tick();
    serIn = 1'b1; tick();
    serIn = 1'b1; tick();
    nt_valid = 1'b1; nt = 8'd5; tick();
    nt_valid = 1'b0; serIn = 1'b1; tick(); tick();
    checkOutput("mid-frame data_valid", data_valid, 4'b1000);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset data_valid", data_valid, 0);
    checkOutput("async reset data_out", data_out, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset port_sel", port_sel, 0);
    checkOutput("async reset nt_en", nt_en, 0);
    checkOutput("async reset done", done, 0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      serIn = 1'b1;
      tick();
      checkOutput("busy after reset release", busy, 0);
    end
    expQ.delete();
    monitorOn = 1'b1;

`ifdef MSG_COUNT_EN
    randomBits(bits);
    applyStimulus(1, 2, bits, 1, 1'b1);
    applyStimulus(1, 0, bits, 0, 1'b1);
    applyStimulus(3, 1, bits, 2, 1'b1);
    tick();
    checkOutput("cnt port0", msg_cnt[0*CNT_W +: CNT_W], 0);
    checkOutput("cnt port1", msg_cnt[1*CNT_W +: CNT_W], 2);
    checkOutput("cnt port2", msg_cnt[2*CNT_W +: CNT_W], 0);
    checkOutput("cnt port3", msg_cnt[3*CNT_W +: CNT_W], 1);
`endif

    // Directed frames: 3-bit payload, empty payload, maximum length.
    bits = '0;
    bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
    applyStimulus(2, 3, bits, 2, 1'b1);
    randomBits(bits);
    applyStimulus(1, 0, bits, 1, 1'b1);
    randomBits(bits);
    applyStimulus(3, 255, bits, 1, 1'b1);

    // Line low during DONE, then back-to-back frames.
    for (int k = 0; k < 4; k++) begin
      randomBits(bits);
      applyStimulus(k, k + 1, bits, 0, 1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      randomBits(bits);
      applyStimulus($urandom_range(0, NPORTS - 1),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(13, 40) : $urandom_range(0, 12),
                    bits, $urandom_range(0, 3), 1'($urandom));
    end

`ifdef MSG_COUNT_EN
    tick();
    checkCounts("msg_cnt after random frames");
    for (int k = 0; k < 256; k++) begin
      randomBits(bits);
      applyStimulus(0, $urandom_range(0, 2), bits, 0, 1'b1);
    end
    tick();
    checkCounts("msg_cnt after port0 wrap");
`endif

    repeat (3) tick();
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
